// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, drives a 1-cycle-latency imem and buffers {pc, word} for decode.
// Optional FETCH_BYPASS_EN: an arriving word skips the empty buffer and reaches decode in the same cycle.
module fetch_unit #(
  parameter int                   DATAWIDTH = 32,
  parameter int                   ADDRWIDTH = 12,
  parameter int                   FIFODEPTH = 4,
  parameter logic [ADDRWIDTH-1:0] RESETPC   = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  output logic                 imem_re_o,
  output logic [ADDRWIDTH-1:0] imem_raddr_o,
  input  logic [DATAWIDTH-1:0] imem_rdata_i,
  input  logic                 redirect_i,
  input  logic [ADDRWIDTH-1:0] redirect_pc_i,
  output logic                 instr_valid_o,
  input  logic                 instr_ready_i,
  output logic [DATAWIDTH-1:0] instr_o,
  output logic [ADDRWIDTH-1:0] instr_pc_o
);

  localparam int PW = $clog2(FIFODEPTH);
  localparam int CW = PW + 1;

  typedef logic [ADDRWIDTH-1:0] addr_t;
  typedef logic [DATAWIDTH-1:0] word_t;

  addr_t          r_pc;
  addr_t          r_issued_pc;
  logic           r_inflight;
  addr_t          r_fifo_pc   [FIFODEPTH];
  word_t          r_fifo_data [FIFODEPTH];
  logic [PW-1:0]  r_wptr;
  logic [PW-1:0]  r_rptr;
  logic [CW-1:0]  r_count;

  logic           w_empty;
  logic           w_full;
  logic           w_resp_ok;
  logic           w_bypass;
  logic           w_pop;
  logic           w_fifo_pop;
  logic           w_push;
  logic           w_issue;
  logic [CW:0]    w_credit;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CW'(FIFODEPTH));
  // A response is dropped in the redirect cycle; nothing is issued then, so the next cycle is clean too.
  assign w_resp_ok = r_inflight & ~redirect_i;

`ifdef FETCH_BYPASS_EN
  assign w_bypass = w_empty & w_resp_ok;
`else
  assign w_bypass = 1'b0;
`endif

  always_comb begin
    instr_valid_o = ~w_empty;
    instr_o       = r_fifo_data[r_rptr];
    instr_pc_o    = r_fifo_pc[r_rptr];
`ifdef FETCH_BYPASS_EN
    if (w_bypass) begin
      instr_valid_o = 1'b1;
      instr_o       = imem_rdata_i;
      instr_pc_o    = r_issued_pc;
    end
`endif
  end

  assign w_pop      = instr_valid_o & instr_ready_i;
  assign w_fifo_pop = w_pop & ~w_empty;
  assign w_push     = w_resp_ok & ~(w_bypass & instr_ready_i);

  // Credit counts the slot reserved by the read in flight, so a full buffer can never be pushed.
  assign w_credit  = (CW+1)'(r_count) + (CW+1)'(r_inflight) - (CW+1)'(w_pop);
  assign w_issue   = rst_ni & ~redirect_i & (w_credit < (CW+1)'(FIFODEPTH));
  assign imem_re_o    = w_issue;
  assign imem_raddr_o = r_pc;

  // NOTE: the buffer storage is reset because instr_o/instr_pc_o must read zero during reset;
  // every sequential block here uses non-blocking assignments so all state updates see pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < FIFODEPTH; i++) begin
        r_fifo_pc[i]   <= '0;
        r_fifo_data[i] <= '0;
      end
    end else if (w_push) begin
      r_fifo_pc[r_wptr]   <= r_issued_pc;
      r_fifo_data[r_wptr] <= imem_rdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pc        <= RESETPC;
      r_issued_pc <= '0;
      r_inflight  <= 1'b0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
    end else if (redirect_i) begin
      r_pc       <= redirect_pc_i;
      r_inflight <= 1'b0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_pc        <= r_pc + addr_t'(1);
        r_issued_pc <= r_pc;
      end
      if (w_push)     r_wptr <= r_wptr + PW'(1);
      if (w_fifo_pop) r_rptr <= r_rptr + PW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_fifo_pop);
    end
  end

  a_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_ni) !(w_push && w_full));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: startup latency, back-pressure fill, redirects incl. PC wrap,
// random ready/redirect traffic against a PC scoreboard, and mid-stream reset.
module tb_fetch_unit;

  localparam int D  = 4;
`ifdef FETCH_BYPASS_EN
  localparam int FV = 1;
`else
  localparam int FV = 2;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_re;
  logic [11:0] imem_raddr;
  logic [31:0] imem_rdata = '0;
  logic        redirect;
  logic [11:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [11:0] instr_pc;

  int n_checks = 0;
  int n_fail   = 0;
  int n_acc    = 0;

  fetch_unit #(.DATAWIDTH(32), .ADDRWIDTH(12), .FIFODEPTH(D), .RESETPC(12'h000)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .imem_re_o     (imem_re),
    .imem_raddr_o  (imem_raddr),
    .imem_rdata_i  (imem_rdata),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .instr_valid_o (instr_valid),
    .instr_ready_i (instr_ready),
    .instr_o       (instr),
    .instr_pc_o    (instr_pc)
  );

  always #5 clk = ~clk;

  // imem model: word at address n is 0x1000+n, one cycle of read latency.
  always @(posedge clk) if (imem_re) imem_rdata <= 32'h1000 + {20'h0, imem_raddr};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: every handshake must deliver the next sequential PC and its imem word.
  logic [11:0] exp_pc = '0;
  logic [11:0] prev_pc = '0;
  logic        prev_hold = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_pc    = 12'h000;
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", 32'(instr_valid), 32'd1);
        check("hold_pc", 32'(instr_pc), 32'(prev_pc));
      end
      if (instr_valid && instr_ready) begin
        check("stream_pc", 32'(instr_pc), 32'(exp_pc));
        check("stream_data", instr, 32'h1000 + 32'(exp_pc));
        exp_pc = exp_pc + 12'd1;
        n_acc++;
      end
      if (redirect) exp_pc = redirect_pc;
      prev_hold = instr_valid && !instr_ready && !redirect;
      prev_pc   = instr_pc;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Releases reset now (cycle 0) and checks issue address and delivery latency per cycle.
  task automatic startup(input int ncyc);
    rst_n       = 1'b1;
    instr_ready = 1'b1;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      check("start_re", 32'(imem_re), 32'd1);
      check("start_raddr", 32'(imem_raddr), 32'(c));
      check("start_valid", 32'(instr_valid), 32'(c >= FV));
      if (c >= FV) check("start_pc", 32'(instr_pc), 32'(c - FV));
      next_cycle();
    end
  endtask

  task automatic do_redirect(input logic [11:0] tgt);
    logic [11:0] e;
    redirect    = 1'b1;
    redirect_pc = tgt;
    instr_ready = 1'b1;
    next_cycle();
    redirect = 1'b0;
    for (int k = 1; k <= FV + 4; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check("redir_re", 32'(imem_re), 32'd1);
        check("redir_raddr", 32'(imem_raddr), 32'(tgt));
      end
      check("redir_valid", 32'(instr_valid), 32'(k > FV));
      if (k > FV) begin
        e = tgt + 12'(k - FV - 1);
        check("redir_pc", 32'(instr_pc), 32'(e));
      end
      next_cycle();
    end
  endtask

  initial begin
    int gap;
    int base;
    logic [11:0] p;
    rst_n       = 1'b0;
    instr_ready = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_re", 32'(imem_re), 32'd0);
    check("rst_raddr", 32'(imem_raddr), 32'h000);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_pc", 32'(instr_pc), 32'd0);

    startup(8);

    // Back-pressure: head holds, buffer fills to exactly D entries, then fetch stops.
    instr_ready = 1'b0;
    p = 12'(8 - FV);
    for (int s = 0; s < 10; s++) begin
      @(negedge clk);
      check("stall_valid", 32'(instr_valid), 32'd1);
      check("stall_pc", 32'(instr_pc), 32'(p));
      if (s == 9) begin
        check("stall_re", 32'(imem_re), 32'd0);
        check("stall_raddr", 32'(p + 12'(D)), 32'(imem_raddr));
      end
      next_cycle();
    end
    instr_ready = 1'b1;
    repeat (10) next_cycle();

    do_redirect(12'h200);
    repeat (5) next_cycle();
    do_redirect(12'hFFE);

    base = n_acc;
    gap  = $urandom_range(5, 20);
    for (int i = 0; i < 400; i++) begin
      instr_ready = ($urandom_range(0, 3) != 0);
      if (gap == 0) begin
        redirect    = 1'b1;
        redirect_pc = 12'($urandom_range(0, 4095));
        gap         = $urandom_range(5, 20);
      end else begin
        redirect = 1'b0;
        gap--;
      end
      next_cycle();
    end
    redirect    = 1'b0;
    instr_ready = 1'b1;
    check("rand_progress", 32'((n_acc - base) > 100), 32'd1);

    repeat (6) next_cycle();
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(instr_valid), 32'd0);
    check("midrst_re", 32'(imem_re), 32'd0);
    check("midrst_instr", instr, 32'd0);
    check("midrst_pc", 32'(instr_pc), 32'd0);
    next_cycle();
    startup(6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction-fetch front end for the single-clock core. It owns the program counter and drives the instruction memory read port, which has one cycle of read latency. Fetched words are buffered together with their PC in a small FIFO and handed to decode over a valid/ready handshake. A redirect input flushes the pipeline for branches and jumps.

## Interface
- DATAWIDTH, 32, instruction word width
- ADDRWIDTH, 12, word-address width of PC and imem (4096 words)
- FIFODEPTH, 4, instruction buffer entries; power of two, ≥2
- RESETPC, 0, word address fetched first after reset
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  asynchronous, active-low reset
- imem_re_o  out  1  imem read enable
- imem_raddr_o  out  ADDRWIDTH  imem read word address
- imem_rdata_i  in  DATAWIDTH  imem read data, valid the cycle after a read
- redirect_i  in  1  flush and restart fetch at redirect_pc_i
- redirect_pc_i  in  ADDRWIDTH  new PC (word address)
- instr_valid_o  out  1  instr_o/instr_pc_o hold a valid instruction
- instr_ready_i  in  1  decode accepts the instruction
- instr_o  out  DATAWIDTH  instruction word
- instr_pc_o  out  ADDRWIDTH  word address of instr_o

## Operation
- State:
  - pc: next fetch address.
  - inflight: 1 bit; a read was issued last cycle.
  - FIFO of {pc, word}, FIFODEPTH entries, with count.
- pop = instr_valid_o & instr_ready_i.
- Issue:
  - imem_re_o = !redirect_i & (count + inflight − pop < FIFODEPTH).
  - imem_raddr_o = pc.
  - On issue: pc ← pc+1, wrapping modulo 2^ADDRWIDTH (0xFFF → 0x000). inflight ← 1; otherwise inflight ← 0.
- Response: when inflight is set, {issued pc, imem_rdata_i} is pushed, unless dropped. The issued pc is held in a register.
- A push and a pop in the same cycle are both performed; count is unchanged.
- No push ever occurs when full. The issue credit guarantees this; overflow is a design error and is asserted against.
- Redirect (redirect_i=1), which dominates all other events:
  - FIFO cleared and count ← 0.
  - Any response arriving this cycle or next is dropped: inflight ← 0, and the response in flight this cycle is not pushed.
  - pc ← redirect_pc_i.
  - No issue in the redirect cycle.
  - A handshake (pop) in the redirect cycle counts as consumed by decode.
- Consecutive redirects: the last one wins, and no issue occurs while redirect_i is held.

## Timing
- Reset (rst_ni=0, asynchronous) sets:
  - pc=RESETPC, inflight=0, count=0, FIFO storage=0.
  - imem_re_o=0, imem_raddr_o=RESETPC.
  - instr_valid_o=0, instr_o=0, instr_pc_o=0.
- imem_re_o is forced 0 while in reset.
- Cycle 0 is the first cycle after reset release: imem_re_o=1 with addr RESETPC.
- Cycle 1: the response is pushed at the end of the cycle. instr_valid_o=1 in cycle 2; with bypass, in cycle 1.
- Redirect in cycle R:
  - First issue at redirect_pc_i in R+1.
  - instr_valid_o=0 in R+1.
  - First valid at R+3 (R+2 with bypass).
- Sustained throughput is 1 instruction/cycle while instr_ready_i=1.
- instr_ready_i low: the buffer fills, then imem_re_o drops.
  - The head stays stable until accepted.
  - instr_valid_o never drops without a pop or a redirect.
- Reset asserted mid-operation discards all buffered and in-flight words immediately.

## Configuration
- FETCH_BYPASS_EN defined: when the FIFO is empty and a non-dropped response arrives, it is driven on instr_o/instr_pc_o combinationally with instr_valid_o=1 in the same cycle.
  - If it is accepted, it is not pushed.
  - If it is not accepted, it is pushed and becomes the head.
  - Latency is 1 cycle.
- Undefined: all instructions pass through the FIFO, latency is 2 cycles, and there is no combinational path imem_rdata_i→instr_o.

## Test plan
- Reset release, instr_ready_i=1, imem[n]=0x1000+n → instr_pc_o 0,1,2,… in consecutive cycles with instr_o 0x1000,0x1001,…; first valid in cycle 2 (cycle 1 with bypass).
- instr_ready_i=0 for 10 cycles → exactly FIFODEPTH words buffered, imem_re_o=0 afterwards. Release ready → PCs 0..FIFODEPTH−1 in order with none lost or duplicated.
- Redirect to 0x200 while the FIFO holds 3 entries and a read is in flight → no stale PC delivered; next valid has instr_pc_o=0x200, then 0x201.
- redirect_pc_i=0xFFE with ready=1 → PCs 0xFFE, 0xFFF, 0x000, 0x001.
- Random instr_ready_i with redirects every 5–20 cycles, checked against a reference PC model → every delivered {pc, instr} matches imem[pc]; PCs are sequential between redirects.
- Assert rst_ni mid-stream → instr_valid_o and imem_re_o go 0 immediately. After release, fetch restarts at RESETPC.
